dram1_bank_arbiter: RTL and testbench
=====================================

Name: dram1_bank_arbiter

Overview:
- Shares the two-bank, 64-bit DataRAM1 (banks B0/B1, 14-bit row address, 2-cycle read latency, per-bank Busy) between two requesters: A (core load/store) and B (DMA).
- Steers each request to its bank by address bit 3, arbitrates per bank, and returns read data to the originator after the fixed memory latency.
- Sits between the requesters and the DRam1*B0/B1 pins of the DataRAM1 instance.

Parameters:
- ABITS, 18, byte address width (256 KB region)
- STARVE_LIMIT, 4, consecutive B losses before B is forced to win; range 1..15
- LAT, 2, memory read latency in cycles; fixed by the memory

Ports:
- CLK  in  1  clock
- RstN  in  1  asynchronous active-low reset
- a_req  in  1  requester A access valid
- a_wr  in  1  1=write, 0=read
- a_addr  in  ABITS  byte address; bits [2:0] ignored
- a_be  in  8  byte enables (writes only)
- a_wdata  in  64  write data
- a_gnt  out  1  combinational grant; the access is taken at this CLK edge
- a_rvalid  out  1  read data valid
- a_rdata  out  64  read data
- b_req, b_wr, b_addr, b_be, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B
- DRam1AddrBn  out  14  bank n row address (n=0,1), = addr[17:4]
- DRam1EnBn  out  1  bank n enable
- DRam1WrBn  out  1  bank n write
- DRam1ByteEnBn  out  8  bank n byte enables
- DRam1WrDataBn  out  64  bank n write data
- DRam1DataBn  in  64  bank n read data
- DRam1BusyBn  in  1  bank n busy; blocks grants to that bank

Behaviour:
- Bank select: bank = addr[3]. Row = addr[17:4].
- Per bank, in the same cycle:
  - Candidates are the requesters with req=1 targeting that bank.
  - If Busy for that bank is 1, nothing is granted to it.
  - Otherwise, with one candidate, that candidate wins.
  - With both candidates, A wins unless starve_cnt == STARVE_LIMIT, in which case B wins.
- A and B hitting different banks are both granted in the same cycle.
- Grants are combinational from req, addr and Busy. Requesters hold req and payload stable until gnt.
- Memory pins are combinational from the winning requester.
  - With no winner: EnBn=0, WrBn=0, ByteEnBn=0; Addr and WrData are don't-care but driven from A.
  - Read: WrBn=0 and ByteEnBn=0.
- starve_cnt (4-bit, registered):
  - Increments, saturating at STARVE_LIMIT, when b_req=1, b_gnt=0 and B's bank is not Busy.
  - Clears on b_gnt.
  - Otherwise holds.
- Read return:
  - Each bank has a 2-stage shift register of {valid, owner}, loaded at the grant edge with valid = granted & ~wr.
  - The read granted at edge T returns in the cycle after edge T+1: x_rvalid=1 and x_rdata=DRam1DataBn of the owning bank.
  - A requester receives at most one grant per cycle, so at most one return per requester per cycle. No return collision is possible.
- Writes produce no response. A read issued one cycle after a write to the same row returns the new data.
- x_rdata equals the bank data when rvalid=1. Otherwise it is 0.
- Reset (async assert, sync deassert expected externally):
  - starve_cnt=0 and all return pipelines cleared, so rvalid=0.
  - Reads in flight at reset are discarded.
  - All outputs are combinational off cleared state and requests. While RstN=0, grants and memory enables are forced to 0.

Optional Feature:
- DRAM1_ARB_STATS_EN
- Defined: adds outputs stat_conflicts[31:0] and stat_forced[31:0].
  - stat_conflicts counts cycles where both requesters target the same non-busy bank.
  - stat_forced counts B wins caused by the starvation limit.
  - Both counters saturate and reset to 0.
- Undefined: neither ports nor counters exist.

Decomposition:
- Package dram1_arb_pkg holds:
  - owner_e enum {OWN_A, OWN_B}
  - typedef ret_t {logic valid; owner_e owner;}
  - localparams ROW_BITS=14, DATA_BITS=64, BE_BITS=8, BANK_BIT=3
- One sub-module, dram1_bank_slot, instantiated twice. It holds one bank's arbitration, pin muxing and return pipeline.
- The top holds starve_cnt, the rdata/rvalid steering, and the stats counters.

Test Plan:
- A reads 0x00008 and B reads 0x00010 in the same cycle:
  - Both gnt=1.
  - DRam1EnB1 with Addr=0, and DRam1EnB0 with Addr=1.
  - Both rvalid=1 exactly 2 cycles later, with the preloaded data.
- A and B both write bank 0 continuously:
  - A wins 4 cycles, then B wins on the 5th; the pattern repeats.
  - stat_forced increments once per 5 cycles (STATS_EN build).
- A writes 0x10 with be=0x0F and data 0x11223344_55667788, then A reads 0x10 the next cycle:
  - a_rdata = old[63:32] concatenated with 0x55667788.
- DRam1BusyB0=1 for 3 cycles with A requesting bank 0:
  - a_gnt=0 throughout and EnB0=0.
  - Grant on the first cycle after Busy drops.
  - starve_cnt is unchanged if B was waiting on bank 0.
- RstN asserted one cycle after a B read grant:
  - b_rvalid stays 0 and starve_cnt=0.
  - After deassert, a new read returns normally after 2 cycles.
- Idle with b_req only, to bank 1:
  - Granted immediately every cycle and starve_cnt stays 0.
  - Back-to-back reads return in order, one per cycle.

Source files
------------

// File: rtl/dram1_arb_pkg.sv
// Shared types and widths for the DataRAM1 two-bank arbiter.
// The package carries the return-tag layout and the bank geometry.
package dram1_arb_pkg;

  localparam int ROW_BITS  = 14;
  localparam int DATA_BITS = 64;
  localparam int BE_BITS   = 8;
  localparam int BANK_BIT  = 3;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } ret_t;

endpackage

// File: rtl/dram1_bank_slot.sv
// One DataRAM1 bank: A/B arbitration, pin muxing and the read-return tag pipe.
// The tag pipe is LAT deep so the tag lines up with the bank's read data.
module dram1_bank_slot
  import dram1_arb_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 busy_i,
  input  logic                 force_b_i,
  input  logic                 a_cand_i,
  input  logic                 a_wr_i,
  input  logic [ROW_BITS-1:0]  a_row_i,
  input  logic [BE_BITS-1:0]   a_be_i,
  input  logic [DATA_BITS-1:0] a_wdata_i,
  input  logic                 b_cand_i,
  input  logic                 b_wr_i,
  input  logic [ROW_BITS-1:0]  b_row_i,
  input  logic [BE_BITS-1:0]   b_be_i,
  input  logic [DATA_BITS-1:0] b_wdata_i,
  output logic                 a_gnt_o,
  output logic                 b_gnt_o,
  output logic [ROW_BITS-1:0]  mem_addr_o,
  output logic                 mem_en_o,
  output logic                 mem_wr_o,
  output logic [BE_BITS-1:0]   mem_be_o,
  output logic [DATA_BITS-1:0] mem_wdata_o,
  output ret_t                 ret_o
);

  logic a_win;
  logic b_win;
  ret_t tag_d;
  ret_t [LAT-1:0] pipe_q;

  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    if (rst_ni && !busy_i) begin
      unique case ({a_cand_i, b_cand_i})
        2'b11: begin
          a_win = !force_b_i;
          b_win = force_b_i;
        end
        2'b10:   a_win = 1'b1;
        2'b01:   b_win = 1'b1;
        default: ;
      endcase
    end
  end

  assign a_gnt_o = a_win;
  assign b_gnt_o = b_win;

  // Idle pins still follow A so the address bus does not toggle needlessly.
  assign mem_en_o    = a_win | b_win;
  assign mem_wr_o    = b_win ? b_wr_i : (a_win & a_wr_i);
  assign mem_addr_o  = b_win ? b_row_i : a_row_i;
  assign mem_wdata_o = b_win ? b_wdata_i : a_wdata_i;
  assign mem_be_o    = !mem_wr_o ? '0 :
                       (b_win ? b_be_i : a_be_i);

  always_comb begin
    tag_d       = '0;
    tag_d.valid = mem_en_o & ~mem_wr_o;
    tag_d.owner = b_win ? OWN_B : OWN_A;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[LAT-2:0], tag_d};
    end
  end

  assign ret_o = pipe_q[LAT-1];

endmodule

// File: rtl/dram1_bank_arbiter.sv
// Arbitrates core (A) and DMA (B) onto the two DataRAM1 banks.
// Optional counters enabled by DRAM1_ARB_STATS_EN.
module dram1_bank_arbiter
  import dram1_arb_pkg::*;
#(
  parameter int ABITS        = 18,
  parameter int STARVE_LIMIT = 4,
  parameter int LAT          = 2
) (
  input  logic                 CLK,
  input  logic                 RstN,
  input  logic                 a_req,
  input  logic                 a_wr,
  input  logic [ABITS-1:0]     a_addr,
  input  logic [BE_BITS-1:0]   a_be,
  input  logic [DATA_BITS-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [DATA_BITS-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_wr,
  input  logic [ABITS-1:0]     b_addr,
  input  logic [BE_BITS-1:0]   b_be,
  input  logic [DATA_BITS-1:0] b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [DATA_BITS-1:0] b_rdata,
`ifdef DRAM1_ARB_STATS_EN
  output logic [31:0]          stat_conflicts,
  output logic [31:0]          stat_forced,
`endif
  output logic [ROW_BITS-1:0]  DRam1AddrB0,
  output logic                 DRam1EnB0,
  output logic                 DRam1WrB0,
  output logic [BE_BITS-1:0]   DRam1ByteEnB0,
  output logic [DATA_BITS-1:0] DRam1WrDataB0,
  input  logic [DATA_BITS-1:0] DRam1DataB0,
  input  logic                 DRam1BusyB0,
  output logic [ROW_BITS-1:0]  DRam1AddrB1,
  output logic                 DRam1EnB1,
  output logic                 DRam1WrB1,
  output logic [BE_BITS-1:0]   DRam1ByteEnB1,
  output logic [DATA_BITS-1:0] DRam1WrDataB1,
  input  logic [DATA_BITS-1:0] DRam1DataB1,
  input  logic                 DRam1BusyB1
);

  localparam int RLO = BANK_BIT + 1;
  localparam int RHI = BANK_BIT + ROW_BITS;

  logic [3:0] starve_q, starve_d;
  logic       force_b;
  logic       a_bank, b_bank, b_busy;
  logic       a_g0, a_g1, b_g0, b_g1;
  ret_t       ret0, ret1;
  logic       r0a, r1a, r0b, r1b;
  logic       unused_addr_lsb;

  assign unused_addr_lsb = ^{a_addr[BANK_BIT-1:0], b_addr[BANK_BIT-1:0]};

  assign a_bank  = a_addr[BANK_BIT];
  assign b_bank  = b_addr[BANK_BIT];
  assign b_busy  = b_bank ? DRam1BusyB1 : DRam1BusyB0;
  assign force_b = (starve_q == 4'(STARVE_LIMIT));

  dram1_bank_slot #(.LAT(LAT)) u_slot0 (
    .clk_i(CLK), .rst_ni(RstN),
    .busy_i(DRam1BusyB0), .force_b_i(force_b),
    .a_cand_i(a_req & ~a_bank), .a_wr_i(a_wr),
    .a_row_i(a_addr[RHI:RLO]), .a_be_i(a_be),
    .a_wdata_i(a_wdata),
    .b_cand_i(b_req & ~b_bank), .b_wr_i(b_wr),
    .b_row_i(b_addr[RHI:RLO]), .b_be_i(b_be),
    .b_wdata_i(b_wdata),
    .a_gnt_o(a_g0), .b_gnt_o(b_g0),
    .mem_addr_o(DRam1AddrB0), .mem_en_o(DRam1EnB0),
    .mem_wr_o(DRam1WrB0), .mem_be_o(DRam1ByteEnB0),
    .mem_wdata_o(DRam1WrDataB0), .ret_o(ret0)
  );

  dram1_bank_slot #(.LAT(LAT)) u_slot1 (
    .clk_i(CLK), .rst_ni(RstN),
    .busy_i(DRam1BusyB1), .force_b_i(force_b),
    .a_cand_i(a_req & a_bank), .a_wr_i(a_wr),
    .a_row_i(a_addr[RHI:RLO]), .a_be_i(a_be),
    .a_wdata_i(a_wdata),
    .b_cand_i(b_req & b_bank), .b_wr_i(b_wr),
    .b_row_i(b_addr[RHI:RLO]), .b_be_i(b_be),
    .b_wdata_i(b_wdata),
    .a_gnt_o(a_g1), .b_gnt_o(b_g1),
    .mem_addr_o(DRam1AddrB1), .mem_en_o(DRam1EnB1),
    .mem_wr_o(DRam1WrB1), .mem_be_o(DRam1ByteEnB1),
    .mem_wdata_o(DRam1WrDataB1), .ret_o(ret1)
  );

  assign a_gnt = a_g0 | a_g1;
  assign b_gnt = b_g0 | b_g1;

  // B only accrues starvation when it lost to A, not to Busy.
  always_comb begin
    starve_d = starve_q;
    if (b_gnt) begin
      starve_d = '0;
    end else if (b_req && !b_busy && !force_b) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RstN) begin
    if (!RstN) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign r0a = ret0.valid & (ret0.owner == OWN_A);
  assign r1a = ret1.valid & (ret1.owner == OWN_A);
  assign r0b = ret0.valid & (ret0.owner == OWN_B);
  assign r1b = ret1.valid & (ret1.owner == OWN_B);

  assign a_rvalid = r0a | r1a;
  assign b_rvalid = r0b | r1b;
  assign a_rdata  = ({DATA_BITS{r0a}} & DRam1DataB0) |
                    ({DATA_BITS{r1a}} & DRam1DataB1);
  assign b_rdata  = ({DATA_BITS{r0b}} & DRam1DataB0) |
                    ({DATA_BITS{r1b}} & DRam1DataB1);

`ifdef DRAM1_ARB_STATS_EN
  logic [31:0] conf_q, forced_q;
  logic        same_bank, conflict, forced;

  assign same_bank = a_req & b_req & (a_bank == b_bank);
  assign conflict  = same_bank & ~b_busy;
  assign forced    = same_bank & b_gnt;

  always_ff @(posedge CLK or negedge RstN) begin
    if (!RstN) begin
      conf_q   <= '0;
      forced_q <= '0;
    end else begin
      if (conflict && conf_q != '1) conf_q <= conf_q + 32'd1;
      if (forced && forced_q != '1) forced_q <= forced_q + 32'd1;
    end
  end

  assign stat_conflicts = conf_q;
  assign stat_forced    = forced_q;
`endif

endmodule

// File: tb/tb_dram1_bank_arbiter.sv
// Directed bench for dram1_bank_arbiter with a two-bank DataRAM1 model.
// Build with DRAM1_ARB_STATS_EN to also check the forced-win counter.
module tb_dram1_bank_arbiter;

  logic        CLK = 1'b0;
  logic        RstN;
  logic        a_req, a_wr, b_req, b_wr;
  logic [17:0] a_addr, b_addr;
  logic [7:0]  a_be, b_be;
  logic [63:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [63:0] a_rdata, b_rdata;
  logic [13:0] addr0, addr1;
  logic        en0, en1, wr0, wr1;
  logic [7:0]  be0, be1;
  logic [63:0] wd0, wd1;
  logic [63:0] d0 = '0;
  logic [63:0] d1 = '0;
  logic [63:0] p0, p1;
  logic        busy0, busy1;
`ifdef DRAM1_ARB_STATS_EN
  logic [31:0] stat_conflicts, stat_forced;
`endif

  logic [63:0] mem0 [256];
  logic [63:0] mem1 [256];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dram1_bank_arbiter dut (
    .CLK(CLK), .RstN(RstN),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr),
    .a_be(a_be), .a_wdata(a_wdata), .a_gnt(a_gnt),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr),
    .b_be(b_be), .b_wdata(b_wdata), .b_gnt(b_gnt),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
`ifdef DRAM1_ARB_STATS_EN
    .stat_conflicts(stat_conflicts), .stat_forced(stat_forced),
`endif
    .DRam1AddrB0(addr0), .DRam1EnB0(en0), .DRam1WrB0(wr0),
    .DRam1ByteEnB0(be0), .DRam1WrDataB0(wd0),
    .DRam1DataB0(d0), .DRam1BusyB0(busy0),
    .DRam1AddrB1(addr1), .DRam1EnB1(en1), .DRam1WrB1(wr1),
    .DRam1ByteEnB1(be1), .DRam1WrDataB1(wd1),
    .DRam1DataB1(d1), .DRam1BusyB1(busy1)
  );

  // Memory model: sample at the grant edge, present data one edge later.
  always @(posedge CLK) begin
    if (en0 && wr0)
      for (int k = 0; k < 8; k++)
        if (be0[k]) mem0[addr0[7:0]][8*k +: 8] <= wd0[8*k +: 8];
    if (en1 && wr1)
      for (int k = 0; k < 8; k++)
        if (be1[k]) mem1[addr1[7:0]][8*k +: 8] <= wd1[8*k +: 8];
    p0 <= (en0 && !wr0) ? mem0[addr0[7:0]] : 64'hDEAD_DEAD_DEAD_DEAD;
    p1 <= (en1 && !wr1) ? mem1[addr1[7:0]] : 64'hDEAD_DEAD_DEAD_DEAD;
    d0 <= p0;
    d1 <= p1;
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    a_req = 0; a_wr = 0; a_addr = '0; a_be = '0; a_wdata = '0;
    b_req = 0; b_wr = 0; b_addr = '0; b_be = '0; b_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = {32'hA000_0000 + 32'(i), 32'h0A00_0000 + 32'(i)};
      mem1[i] = {32'hB000_0000 + 32'(i), 32'h0B00_0000 + 32'(i)};
    end
    idle();
    busy0 = 0; busy1 = 0;
    RstN  = 0;
    a_req = 1;
    @(negedge CLK);
    #1;
    check("rst_agnt", a_gnt, 0);
    check("rst_en0", en0, 0);
    check("rst_arv", a_rvalid, 0);
    check("rst_brv", b_rvalid, 0);
    @(negedge CLK);
    RstN = 1;
    idle();
    @(negedge CLK);

    // Two reads to different banks in one cycle
    a_req = 1; a_addr = 18'h00008;
    b_req = 1; b_addr = 18'h00010;
    #1;
    check("t1_agnt", a_gnt, 1);
    check("t1_bgnt", b_gnt, 1);
    check("t1_en1", en1, 1);
    check("t1_addr1", addr1, 0);
    check("t1_en0", en0, 1);
    check("t1_addr0", addr0, 1);
    check("t1_be0", be0, 0);
    @(negedge CLK);
    idle();
    #1;
    check("t1_arv_early", a_rvalid, 0);
    @(negedge CLK);
    check("t1_arv", a_rvalid, 1);
    check("t1_ard", a_rdata, 64'hB000_0000_0B00_0000);
    check("t1_brv", b_rvalid, 1);
    check("t1_brd", b_rdata, 64'hA000_0001_0A00_0001);
    @(negedge CLK);
    check("t1_arv_late", a_rvalid, 0);
    check("t1_ard_zero", a_rdata, 0);

    // Continuous write contention on bank 0: 4 A wins then one forced B win
    a_req = 1; a_wr = 1; a_addr = 18'h00000; a_be = 8'hFF;
    a_wdata = 64'h1111_1111_1111_1111;
    b_req = 1; b_wr = 1; b_addr = 18'h00020; b_be = 8'hFF;
    b_wdata = 64'h2222_2222_2222_2222;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("t2_agnt%0d", i), a_gnt, (i % 5 == 4) ? 0 : 1);
      check($sformatf("t2_bgnt%0d", i), b_gnt, (i % 5 == 4) ? 1 : 0);
      @(negedge CLK);
    end
`ifdef DRAM1_ARB_STATS_EN
    check("t2_forced", stat_forced, 2);
    check("t2_conf", stat_conflicts, 10);
`endif
    idle();
    @(negedge CLK);

    // Partial write then read-after-write to the same row
    a_req = 1; a_wr = 1; a_addr = 18'h00010; a_be = 8'h0F;
    a_wdata = 64'h1122_3344_5566_7788;
    #1;
    check("t3_wgnt", a_gnt, 1);
    check("t3_wr0", wr0, 1);
    check("t3_be0", be0, 8'h0F);
    @(negedge CLK);
    a_wr = 0; a_be = 8'h00;
    #1;
    check("t3_rgnt", a_gnt, 1);
    @(negedge CLK);
    idle();
    #1;
    check("t3_no_wresp", a_rvalid, 0);
    @(negedge CLK);
    check("t3_rv", a_rvalid, 1);
    check("t3_rd", a_rdata, 64'hA000_0001_5566_7788);
    @(negedge CLK);

    // Busy on bank 0 blocks A; B waiting there does not accrue starvation
    busy0 = 1;
    a_req = 1; a_addr = 18'h00000;
    b_req = 1; b_addr = 18'h00030;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t4_agnt%0d", i), a_gnt, 0);
      check($sformatf("t4_en0_%0d", i), en0, 0);
      @(negedge CLK);
    end
    check("t4_starve", dut.starve_q, 0);
    busy0 = 0;
    #1;
    check("t4_agnt_rel", a_gnt, 1);
    check("t4_bgnt_rel", b_gnt, 0);
    @(negedge CLK);
    check("t4_starve1", dut.starve_q, 1);
    idle();
    repeat (3) @(negedge CLK);

    // Reset in the cycle after a B read grant discards the read
    b_req = 1; b_addr = 18'h00018;
    #1;
    check("t5_bgnt", b_gnt, 1);
    @(negedge CLK);
    RstN = 0;
    #1;
    check("t5_bgnt_rst", b_gnt, 0);
    check("t5_en1_rst", en1, 0);
    check("t5_brv0", b_rvalid, 0);
    @(negedge CLK);
    check("t5_brv1", b_rvalid, 0);
    check("t5_starve", dut.starve_q, 0);
    @(negedge CLK);
    RstN = 1;
    #1;
    check("t5_bgnt_new", b_gnt, 1);
    @(negedge CLK);
    idle();
    #1;
    check("t5_brv_early", b_rvalid, 0);
    @(negedge CLK);
    check("t5_brv", b_rvalid, 1);
    check("t5_brd", b_rdata, 64'hB000_0001_0B00_0001);
    @(negedge CLK);

    // B alone streams reads to bank 1, returned in order
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        b_req = 1; b_addr = 18'(i * 16 + 8);
      end else begin
        b_req = 0;
      end
      #1;
      if (i < 3) check($sformatf("t6_bgnt%0d", i), b_gnt, 1);
      if (i >= 2) begin
        check($sformatf("t6_brv%0d", i), b_rvalid, 1);
        check($sformatf("t6_brd%0d", i), b_rdata,
              {32'hB000_0000 + 32'(i - 2), 32'h0B00_0000 + 32'(i - 2)});
      end
      check($sformatf("t6_starve%0d", i), dut.starve_q, 0);
      @(negedge CLK);
    end
    check("t6_brv_end", b_rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
